alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter W, default 3: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block accepts a transaction this cycle.
REQ-006 in_a  input  W  operand A.
REQ-007 in_b  input  W  operand B.
REQ-008 in_op  input  3  opcode.
REQ-009 out_valid  output  1  result held on outputs.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_result  output  2W  result, zero-extended.
REQ-012 out_carry  output  1  ADD carry-out or SUB borrow; 0 for other ops.
REQ-013 out_zero  output  1  out_result == 0.
REQ-014 out_err  output  1  opcode not supported in this build.

Function
REQ-015 Accept on the rising edge where in_valid && in_ready; in_a, in_b and in_op are captured there, and inputs are ignored otherwise.
REQ-016 FSM states: IDLE, MUL, DONE.
- IDLE -> DONE on acceptance of a single-cycle op.
- IDLE -> MUL on acceptance of MUL.
- MUL -> DONE after W iterations.
- DONE -> IDLE on out_ready with no new acceptance.
REQ-017 in_ready = (state==IDLE) || (state==DONE && out_ready); this gives back-to-back single-cycle ops at 1 per cycle.
REQ-018 Single-cycle op latency: out_valid is high in the cycle after acceptance. MUL latency: W+1 cycles.
REQ-019 Opcode results (mod 2^W unless stated):
- 000 ADD = a+b, W+1 bits, carry = bit W.
- 001 SUB = (a-b) mod 2^W, borrow = (a<b).
- 010 XNOR = bitwise ~(a^b).
- 011 SHR = a>>1, logical.
- 100 SHL = (a<<1) mod 2^W.
- 101 AND.
- 110 OR.
- 111 MUL = a*b, full 2W bits.
REQ-020 While out_valid && !out_ready, out_result, out_carry, out_zero and out_err stay stable, and in_ready=0.
REQ-021 In state MUL, in_ready=0; in_valid is ignored and no operands are captured.
REQ-022 out_zero is computed on the final out_result in every case, including err results.
REQ-023 No transaction is dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-024 Asserting rst_n low forces the following, immediately and regardless of clk: state=IDLE, in_ready=1 after release, out_valid=0, out_result=0, out_carry=0, out_zero=0, out_err=0.
REQ-025 A reset during MUL or DONE discards the in-flight transaction; no out_valid follows reset release until a new acceptance.
REQ-026 Release of rst_n is synchronised by the instantiating level; the block requires no internal deassertion handling.

Configuration
REQ-027 Macro ALU_PIPE_MUL_EN.
- Defined: opcode 111 performs iterative shift-add multiply per REQ-016/018/019.
- Undefined: opcode 111 completes as a single-cycle op with out_result=0, out_carry=0, out_zero=1, out_err=1. The MUL state and multiplier logic are absent, and port list and widths are unchanged.

Structure
REQ-028 Package alu_pipe_pkg holds:
- opcode enum (ADD..MUL, 3 bits);
- FSM state enum;
- localparam OP_W=3.
REQ-029 Sub-module alu_pipe_mul implements the iterative multiplier:
- ports clk, rst_n, start, a, b, busy, done, product;
- one partial-product step per cycle, W cycles;
- instantiated only under ALU_PIPE_MUL_EN.
REQ-030 The single-cycle datapath is combinational in alu_pipe, registered once into the output register.

Verification
REQ-031 W=3, ADD a=7 b=7 accepted at cycle 0 -> cycle 1: out_valid=1, out_result=14, carry=1, zero=0.
REQ-032 W=3, SUB a=2 b=5 -> out_result=5, carry(borrow)=1. SUB a=5 b=5 -> out_result=0, zero=1, carry=0.
REQ-033 W=3, XNOR a=5 b=5 -> 7. SHR a=6 -> 3. SHL a=6 -> 4.
REQ-034 W=3, MUL_EN defined, MUL a=7 b=6 -> in_ready=0 for cycles 1-3, out_valid at cycle 4, out_result=42. With the macro undefined, the same stimulus gives err=1 and result=0 at cycle 1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles after ADD 3+4 -> out_result=7 stable and in_ready=0 throughout. Then, with out_ready=1 and a new in_valid in the same cycle, the next op is accepted with no gap.
REQ-036 Assert rst_n=0 mid-MUL (cycle 2), release at cycle 4 -> all outputs 0 immediately, in_ready=1 after release, and no stale out_valid follows.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: opcode and FSM state encodings.
package alu_pipe_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_XNOR = 3'b010,
      OP_SHR  = 3'b011,
      OP_SHL  = 3'b100,
      OP_AND  = 3'b101,
      OP_OR   = 3'b110,
      OP_MUL  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier: first partial product on start, W steps total,
// done pulses for one cycle with product valid.
module alu_pipe_mul
   import alu_pipe_pkg::*;
#(
   parameter int unsigned W = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int unsigned RW    = 2 * W;
   localparam int unsigned CNT_W = $clog2(W + 1);

   logic [RW-1:0]    acc;
   logic [RW-1:0]    mcand;
   logic [W-1:0]     mplier;
   logic [CNT_W-1:0] cnt;

   assign product = acc;

   // Step 1 folds into the start cycle so the final step lands W-1 cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            acc    <= b[0] ? RW'(a) : '0;
            mcand  <= RW'(a) << 1;
            mplier <= b >> 1;
            cnt    <= CNT_W'(W - 1);
            busy   <= 1'b1;
         end else if (busy) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Small pipelined ALU with valid/ready handshake. Define ALU_PIPE_MUL_EN to
// enable the iterative multiplier; otherwise opcode 111 returns an error result.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int unsigned W = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   input  logic [2:0]     in_op,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_result,
   output logic           out_carry,
   output logic           out_zero,
   output logic           out_err
);

   localparam int unsigned RW = 2 * W;

   state_e        state;
   op_e           op;
   logic          accept;
   logic          mul_idle;
   logic [W:0]    sum_v;
   logic [W-1:0]  diff_v, xnor_v, shr_v, shl_v, and_v, or_v;
   logic [RW-1:0] alu_res;
   logic          alu_carry;
   logic          alu_err;
   logic          alu_zero;

`ifdef ALU_PIPE_MUL_EN
   logic          mul_busy;
   logic          mul_done;
   logic [RW-1:0] mul_product;

   alu_pipe_mul #(.W(W)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept && (op == OP_MUL)),
      .a       (in_a),
      .b       (in_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign mul_idle = !mul_busy;
`else
   assign mul_idle = 1'b1;
`endif

   assign op       = op_e'(in_op);
   assign in_ready = mul_idle && ((state == ST_IDLE) || (state == ST_DONE && out_ready));
   assign accept   = in_valid && in_ready;

   // W-bit intermediates keep each op's result truncated before zero-extension.
   assign sum_v  = {1'b0, in_a} + {1'b0, in_b};
   assign diff_v = in_a - in_b;
   assign xnor_v = ~(in_a ^ in_b);
   assign shr_v  = in_a >> 1;
   assign shl_v  = in_a << 1;
   assign and_v  = in_a & in_b;
   assign or_v   = in_a | in_b;

   // Single-cycle datapath, captured into the output register on acceptance.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_err   = 1'b0;
      case (op)
         OP_ADD:  begin alu_res = RW'(sum_v); alu_carry = sum_v[W]; end
         OP_SUB:  begin alu_res = RW'(diff_v); alu_carry = (in_a < in_b); end
         OP_XNOR: alu_res = RW'(xnor_v);
         OP_SHR:  alu_res = RW'(shr_v);
         OP_SHL:  alu_res = RW'(shl_v);
         OP_AND:  alu_res = RW'(and_v);
         OP_OR:   alu_res = RW'(or_v);
`ifdef ALU_PIPE_MUL_EN
         OP_MUL:  alu_res = '0;
`else
         OP_MUL:  alu_err = 1'b1;
`endif
         default: alu_res = '0;
      endcase
   end

   assign alu_zero = (alu_res == '0);

   // Control FSM with registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_carry  <= 1'b0;
         out_zero   <= 1'b0;
         out_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
`ifdef ALU_PIPE_MUL_EN
                  if (op == OP_MUL) begin
                     state     <= ST_MUL;
                     out_valid <= 1'b0;
                  end else
`endif
                  begin
                     state      <= ST_DONE;
                     out_valid  <= 1'b1;
                     out_result <= alu_res;
                     out_carry  <= alu_carry;
                     out_zero   <= alu_zero;
                     out_err    <= alu_err;
                  end
               end else if (state == ST_DONE && out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
`ifdef ALU_PIPE_MUL_EN
            ST_MUL: begin
               if (mul_done) begin
                  state      <= ST_DONE;
                  out_valid  <= 1'b1;
                  out_result <= mul_product;
                  out_carry  <= 1'b0;
                  out_zero   <= (mul_product == '0);
                  out_err    <= 1'b0;
               end
            end
`endif
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed literal checks plus random traffic
// compared every cycle against a transaction-level model.
module tb_alu_pipe;

   localparam int W = 3;
   localparam int M = 1 << W;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_a = '0;
   logic [W-1:0]   in_b = '0;
   logic [2:0]     in_op = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [2*W-1:0] out_result;
   logic           out_carry;
   logic           out_zero;
   logic           out_err;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model: result held for the consumer, remaining multiply cycles, pending product.
   bit     m_has = 1'b0;
   int     m_mul_left = 0;
   longint m_res = 0;
   bit     m_carry = 1'b0;
   bit     m_err = 1'b0;
   longint m_pend = 0;

   alu_pipe #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .out_err    (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_calc(input int a, input int b, input int op,
                                    output longint r, output bit c, output bit e);
      r = 0; c = 1'b0; e = 1'b0;
      case (op)
         0: begin r = a + b; c = (r >= M); end
         1: begin r = (a - b + M) % M; c = (a < b); end
         2: r = (~(a ^ b)) & (M - 1);
         3: r = a / 2;
         4: r = (a * 2) % M;
         5: r = a & b;
         6: r = a | b;
         default: begin
`ifdef ALU_PIPE_MUL_EN
            r = a * b;
`else
            e = 1'b1;
`endif
         end
      endcase
   endfunction

   function automatic bit model_ready();
      return (m_mul_left == 0) && (!m_has || out_ready);
   endfunction

   task automatic model_reset();
      m_has = 1'b0;
      m_mul_left = 0;
   endtask

   // Advance the model by one clock edge using the inputs presented this cycle.
   task automatic model_step();
      bit acc;
      longint r;
      bit c, e;
      acc = in_valid && model_ready();
      if (m_mul_left > 0) begin
         m_mul_left--;
         if (m_mul_left == 0) begin
            m_has = 1'b1; m_res = m_pend; m_carry = 1'b0; m_err = 1'b0;
         end
      end else if (m_has && out_ready) begin
         m_has = 1'b0;
      end
      if (acc) begin
         ref_calc(int'(in_a), int'(in_b), int'(in_op), r, c, e);
`ifdef ALU_PIPE_MUL_EN
         if (in_op == 3'd7) begin
            m_mul_left = W; m_pend = r; m_has = 1'b0;
         end else
`endif
         begin
            m_has = 1'b1; m_res = r; m_carry = c; m_err = e;
         end
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("in_ready", 64'(in_ready), 64'(model_ready()));
         chk("out_valid", 64'(out_valid), 64'(m_has));
         if (m_has) begin
            chk("out_result", 64'(out_result), 64'(m_res));
            chk("out_carry", 64'(out_carry), 64'(m_carry));
            chk("out_zero", 64'(out_zero), 64'(m_res == 0));
            chk("out_err", 64'(out_err), 64'(m_err));
         end
      end
   end

   task automatic drive(input bit v, input int a, input int b, input int op, input bit ordy);
      in_valid  = v;
      in_a      = W'(a);
      in_b      = W'(b);
      in_op     = 3'(op);
      out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic at_mid();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input int v, input int r, input int c, input int z, input int e);
      chk({name, ".valid"}, 64'(out_valid), 64'(v));
      chk({name, ".result"}, 64'(out_result), 64'(r));
      chk({name, ".carry"}, 64'(out_carry), 64'(c));
      chk({name, ".zero"}, 64'(out_zero), 64'(z));
      chk({name, ".err"}, 64'(out_err), 64'(e));
   endtask

   initial begin
      model_reset();
      #12;
      chk_out("reset", 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("ready_after_reset", 64'(in_ready), 64'd1);
      chk_en = 1'b1;

      // ADD 7+7 then SUB/XNOR/SHR/SHL back to back
      drive(1, 7, 7, 0, 1); tick();
      drive(1, 2, 5, 1, 1); at_mid(); chk_out("add77", 1, 14, 1, 0, 0); tick();
      drive(1, 5, 5, 1, 1); at_mid(); chk_out("sub25", 1, 5, 1, 0, 0); tick();
      drive(1, 5, 5, 2, 1); at_mid(); chk_out("sub55", 1, 0, 0, 1, 0); tick();
      drive(1, 6, 0, 3, 1); at_mid(); chk_out("xnor55", 1, 7, 0, 0, 0); tick();
      drive(1, 6, 0, 4, 1); at_mid(); chk_out("shr6", 1, 3, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 1); at_mid(); chk_out("shl6", 1, 4, 0, 0, 0); tick();
      tick();

      // MUL 7*6 with in_valid held high while the multiply runs
      drive(1, 7, 6, 7, 1); tick();
`ifdef ALU_PIPE_MUL_EN
      for (int i = 0; i < W; i++) begin
         drive(1, 3, 3, 0, 1);
         at_mid();
         chk("mul_busy_ready", 64'(in_ready), 64'd0);
         chk("mul_busy_valid", 64'(out_valid), 64'd0);
         tick();
      end
      drive(0, 0, 0, 0, 1); at_mid(); chk_out("mul76", 1, 42, 0, 0, 0); tick();
`else
      drive(0, 0, 0, 0, 1); at_mid(); chk_out("mul76_err", 1, 0, 0, 1, 1); tick();
`endif
      tick();

      // Backpressure: ADD 3+4 held for 5 cycles, then zero-gap handoff
      drive(1, 3, 4, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         at_mid();
         chk("bp_result", 64'(out_result), 64'd7);
         chk("bp_ready", 64'(in_ready), 64'd0);
         tick();
      end
      drive(1, 1, 1, 5, 1); at_mid(); chk("bp_handoff_ready", 64'(in_ready), 64'd1); tick();
      drive(0, 0, 0, 0, 1); at_mid(); chk_out("and11", 1, 1, 0, 0, 0); tick();

      // Reset in the middle of a MUL (or of its error result)
      drive(1, 7, 6, 7, 0); tick();
      drive(0, 0, 0, 0, 0); tick();
      #2; rst_n = 1'b0; model_reset(); #1;
      chk_out("async_reset", 0, 0, 0, 0, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      chk("ready_after_release", 64'(in_ready), 64'd1);
      drive(0, 0, 0, 0, 1);
      for (int i = 0; i < W + 3; i++) begin
         at_mid();
         chk("no_stale_valid", 64'(out_valid), 64'd0);
         tick();
      end

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, M - 1)),
               int'($urandom_range(0, M - 1)), int'($urandom_range(0, 7)),
               $urandom_range(0, 2) != 0);
         tick();
      end
      drive(0, 0, 0, 0, 1);
      for (int i = 0; i < W + 3; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
